// File: rtl/cdbus_csr_master.sv
// CSR-side master for a CDBUS controller: polls INT_FLAG, streams RX pages out,
// streams TX bytes into REG_TX, and clears error flags.
module cdbus_csr_master #(
  parameter int         MAX_FRAME    = 256,
  parameter logic [7:0] INT_MASK_VAL = 8'h4E
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata,
  input  logic       irq,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic       err,
  output logic       busy
);

  localparam logic [4:0] A_INT_FLAG = 5'h09;
  localparam logic [4:0] A_INT_MASK = 5'h0A;
  localparam logic [4:0] A_RX       = 5'h0B;
  localparam logic [4:0] A_TX       = 5'h0C;
  localparam logic [4:0] A_RX_CTRL  = 5'h0D;
  localparam logic [4:0] A_TX_CTRL  = 5'h0E;
  localparam logic [4:0] A_RX_ADDR  = 5'h0F;
  localparam logic [8:0] MAX_CNT    = 9'(MAX_FRAME);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_POLL, S_ERR_CLR, S_RX_LEN, S_RX_REWIND,
    S_RX_DATA, S_RX_DONE, S_TX_DATA, S_TX_SWITCH, S_TX_DROP
  } state_t;

  state_t     state_q;
  logic       rd_q, wr_q;
  logic [4:0] addr_q;
  logic [7:0] wdata_q;
  logic       tx_ready_q;
  logic       rx_valid_q, rx_last_q;
  logic [7:0] rx_data_q;
  logic       err_q, busy_q;
  logic [8:0] cnt_q;
  logic       step_q;
  logic       cd_pend_q;

  logic       tx_acc, tx_wr, rx_rd, rx_acc;
  logic [8:0] tx_cnt_d;

  // Both streams use valid/ready: a byte transfers on a rising edge where valid
  // and ready are both high; valid and its payload hold until that edge.
  assign tx_acc   = (state_q == S_TX_DATA || state_q == S_TX_DROP) && tx_valid && tx_ready_q;
  assign tx_wr    = (state_q == S_TX_DATA) && tx_valid && tx_ready_q;
  assign rx_rd    = (state_q == S_RX_DATA) && (cnt_q != 9'd0) && (!rx_valid_q || rx_ready);
  assign rx_acc   = rx_valid_q && rx_ready;
  assign tx_cnt_d = cnt_q + 9'd1;

  // Scheduled accesses are registered; only the streaming REG_TX write and
  // REG_RX read are combinational so they line up with their handshakes.
  assign csr_read      = rd_q | rx_rd;
  assign csr_write     = wr_q | tx_wr;
  assign csr_address   = tx_wr ? A_TX : (rx_rd ? A_RX : addr_q);
  assign csr_writedata = tx_wr ? tx_data : wdata_q;

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_last  = rx_last_q;
  assign err      = err_q;
  assign busy     = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      cd_pend_q  <= 1'b0;
    end else begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          wr_q    <= 1'b1;
          addr_q  <= A_INT_MASK;
          wdata_q <= INT_MASK_VAL;
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_IDLE: begin
          if (irq || tx_valid) begin
            rd_q    <= 1'b1;
            addr_q  <= A_INT_FLAG;
            state_q <= S_POLL;
            busy_q  <= 1'b1;
          end
        end
        S_POLL: begin
          if (csr_readdata[2] || csr_readdata[3] || csr_readdata[6]) begin
            wr_q      <= 1'b1;
            cd_pend_q <= (csr_readdata[2] || csr_readdata[3]) && csr_readdata[6];
            if (csr_readdata[2] || csr_readdata[3]) begin
              addr_q  <= A_RX_CTRL;
              wdata_q <= 8'h0C;
            end else begin
              addr_q  <= A_TX_CTRL;
              wdata_q <= 8'h08;
            end
            state_q <= S_ERR_CLR;
          end else if (csr_readdata[1]) begin
            wr_q    <= 1'b1;
            addr_q  <= A_RX_ADDR;
            wdata_q <= 8'h02;
            step_q  <= 1'b0;
            state_q <= S_RX_LEN;
          end else if (tx_valid && csr_readdata[4]) begin
            tx_ready_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_TX_DATA;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_ERR_CLR: begin
          if (cd_pend_q) begin
            wr_q      <= 1'b1;
            addr_q    <= A_TX_CTRL;
            wdata_q   <= 8'h08;
            cd_pend_q <= 1'b0;
          end else begin
            err_q   <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= A_INT_FLAG;
            state_q <= S_POLL;
          end
        end
        S_RX_LEN: begin
          if (!step_q) begin
            rd_q   <= 1'b1;
            addr_q <= A_RX;
            step_q <= 1'b1;
          end else begin
            // Page length byte excludes the 3-byte header.
            cnt_q   <= {1'b0, csr_readdata} + 9'd3;
            wr_q    <= 1'b1;
            addr_q  <= A_RX_ADDR;
            wdata_q <= 8'h00;
            state_q <= S_RX_REWIND;
          end
        end
        S_RX_REWIND: begin
          state_q <= S_RX_DATA;
        end
        S_RX_DATA: begin
          if (rx_rd) begin
            rx_data_q  <= csr_readdata;
            rx_valid_q <= 1'b1;
            rx_last_q  <= (cnt_q == 9'd1);
            cnt_q      <= cnt_q - 9'd1;
          end else if (rx_acc) begin
            rx_valid_q <= 1'b0;
            rx_last_q  <= 1'b0;
            if (cnt_q == 9'd0) begin
              wr_q    <= 1'b1;
              addr_q  <= A_RX_CTRL;
              wdata_q <= 8'h02;
              state_q <= S_RX_DONE;
            end
          end
        end
        S_RX_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_TX_DATA: begin
          if (tx_acc) begin
            cnt_q <= tx_cnt_d;
            if (tx_last) begin
              tx_ready_q <= 1'b0;
              wr_q       <= 1'b1;
              addr_q     <= A_TX_CTRL;
              wdata_q    <= 8'h02;
              state_q    <= S_TX_SWITCH;
            end else if (tx_cnt_d == MAX_CNT) begin
              // Oversized frame: rewind the TX buffer without switching it out.
              wr_q    <= 1'b1;
              addr_q  <= A_TX_CTRL;
              wdata_q <= 8'h01;
              err_q   <= 1'b1;
              state_q <= S_TX_DROP;
            end
          end
        end
        S_TX_SWITCH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_TX_DROP: begin
          if (tx_acc && tx_last) begin
            tx_ready_q <= 1'b0;
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdbus_csr_master.sv
// Bench for cdbus_csr_master: behavioural CDBUS register model, CSR access and
// RX byte scoreboards, table-driven RX/TX frames plus reset corner cases.
module tb_cdbus_csr_master;

  localparam logic [4:0] A_INT_FLAG = 5'h09;
  localparam logic [4:0] A_INT_MASK = 5'h0A;
  localparam logic [4:0] A_RX       = 5'h0B;
  localparam logic [4:0] A_TX       = 5'h0C;
  localparam logic [4:0] A_RX_CTRL  = 5'h0D;
  localparam logic [4:0] A_TX_CTRL  = 5'h0E;
  localparam logic [4:0] A_RX_ADDR  = 5'h0F;
  localparam int         MAXF       = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] csr_address;
  logic       csr_read, csr_write;
  logic [7:0] csr_readdata, csr_writedata;
  logic       irq;
  logic       tx_valid, tx_ready, tx_last;
  logic [7:0] tx_data;
  logic       rx_valid, rx_ready, rx_last;
  logic [7:0] rx_data;
  logic       err, busy;

  cdbus_csr_master #(.MAX_FRAME(256), .INT_MASK_VAL(8'h4E)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata), .irq(irq),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- CDBUS register model ----------------
  logic [7:0] cfg_page [0:511];
  logic [7:0] cfg_flag;
  logic       cfg_load;
  logic [7:0] flag;
  logic [8:0] rx_ptr;

  assign irq = |(flag & 8'h4E);

  always_comb begin
    csr_readdata = 8'h00;
    case (csr_address)
      A_INT_FLAG: csr_readdata = flag;
      A_RX:       csr_readdata = cfg_page[rx_ptr];
      default:    csr_readdata = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (cfg_load) flag <= cfg_flag;
    else if (csr_write && csr_address == A_RX_CTRL) flag <= flag & ~(csr_writedata & 8'h0E);
    else if (csr_write && csr_address == A_TX_CTRL && csr_writedata[3]) flag <= flag & ~8'h40;
    if (csr_write && csr_address == A_RX_ADDR) rx_ptr <= {1'b0, csr_writedata};
    else if (csr_read && csr_address == A_RX) rx_ptr <= rx_ptr + 9'd1;
  end

  // ---------------- scoreboard state ----------------
  logic [13:0] exp_q[$];
  logic [8:0]  rx_exp_q[$];
  int          vec_cnt = 0;
  int          miss_cnt = 0;
  int          err_seen = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic        tx_acc_seen = 1'b0;
  logic        hold_q = 1'b0;
  logic        hold_last;
  logic [7:0]  hold_data;
  logic [7:0]  tx_buf [0:511];
  logic [7:0]  tx_fix [0:3];

  typedef struct {
    logic [7:0] flag;
    int         plen;
    int         mode;
    bit         fixed;
    int         exp_err;
  } rx_vec_t;

  typedef struct {
    int n;
    bit gaps;
    bit fixed;
    int exp_err;
  } tx_vec_t;

  rx_vec_t rx_tab [7];
  tx_vec_t tx_tab [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_acc(input bit w, input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back({w, a, w ? d : 8'h00});
  endtask

  // One clock: monitor at the falling edge, drive just after the rising edge.
  task automatic tick();
    logic [13:0] rec;
    @(negedge clk);
    tx_acc_seen = tx_valid && tx_ready;
    if (csr_read && csr_write) chk("csr_exclusive", 1, 0);
    if (csr_read ^ csr_write) begin
      rec = {csr_write, csr_address, csr_write ? csr_writedata : 8'h00};
      if (exp_q.size() == 0) chk("csr_unexpected_access", {18'd0, rec}, 32'hFFFF_FFFF);
      else chk("csr_access", {18'd0, rec}, {18'd0, exp_q.pop_front()});
    end
    if (err) err_seen++;
    if (hold_q) chk("rx_stable", {rx_valid, rx_last, rx_data}, {1'b1, hold_last, hold_data});
    if (rx_valid && rx_ready) begin
      if (rx_exp_q.size() == 0) chk("rx_unexpected_byte", {rx_last, rx_data}, 32'hFFFF_FFFF);
      else chk("rx_byte", {rx_last, rx_data}, {23'd0, rx_exp_q.pop_front()});
    end
    hold_q    = rx_valid && !rx_ready;
    hold_last = rx_last;
    hold_data = rx_data;
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      1:       rx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       rx_ready = 1'($urandom_range(0, 1));
      default: rx_ready = 1'b1;
    endcase
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rx_exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("done_within_budget", (n < budget), 1);
    repeat (6) tick();
    chk("idle_outputs", {busy, tx_ready, rx_valid}, 0);
  endtask

  task automatic build_page(input int plen, input bit fixed);
    cfg_page[0] = fixed ? 8'h05 : 8'($urandom_range(0, 255));
    cfg_page[1] = fixed ? 8'h00 : 8'($urandom_range(0, 255));
    cfg_page[2] = 8'(plen);
    for (int k = 0; k < plen; k++) cfg_page[3 + k] = 8'($urandom_range(0, 255));
    if (fixed) begin
      cfg_page[3] = 8'hAA;
      cfg_page[4] = 8'hBB;
    end
  endtask

  task automatic expect_rx(input int plen);
    int len = plen + 3;
    push_acc(1, A_RX_ADDR, 8'h02);
    push_acc(0, A_RX, 8'h00);
    push_acc(1, A_RX_ADDR, 8'h00);
    for (int k = 0; k < len; k++) begin
      push_acc(0, A_RX, 8'h00);
      rx_exp_q.push_back({(k == len - 1), cfg_page[k]});
    end
    push_acc(1, A_RX_CTRL, 8'h02);
  endtask

  task automatic load_flag(input logic [7:0] f);
    cfg_flag = f;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    rx_tab[0] = '{8'h12,   2, 0, 1'b1, 0};
    rx_tab[1] = '{8'h12,   2, 1, 1'b1, 0};
    rx_tab[2] = '{8'h4A,   2, 0, 1'b1, 1};
    rx_tab[3] = '{8'h12,   0, 2, 1'b0, 0};
    rx_tab[4] = '{8'h1A, 255, 2, 1'b0, 1};
    rx_tab[5] = '{8'h54,   0, 0, 1'b0, 1};
    rx_tab[6] = '{8'h16,  17, 1, 1'b0, 1};
    tx_tab[0] = '{4,   1'b0, 1'b1, 0};
    tx_tab[1] = '{1,   1'b1, 1'b0, 0};
    tx_tab[2] = '{256, 1'b0, 1'b0, 0};
    tx_tab[3] = '{257, 1'b1, 1'b0, 1};
    tx_tab[4] = '{300, 1'b0, 1'b0, 1};
    tx_fix[0] = 8'h00; tx_fix[1] = 8'h05; tx_fix[2] = 8'h01; tx_fix[3] = 8'hCC;

    // ---- reset and INIT ----
    reset = 1'b1;
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
    cfg_flag = 8'h10; cfg_load = 1'b1;
    tick();
    tick();
    cfg_load = 1'b0;
    chk("reset_strobes", {csr_read, csr_write, tx_ready, rx_valid, rx_last, err, busy}, 0);
    chk("reset_address", csr_address, 0);
    chk("reset_rx_data", rx_data, 0);
    push_acc(1, A_INT_MASK, 8'h4E);
    reset = 1'b0;
    repeat (20) tick();
    chk("init_single_write", exp_q.size(), 0);
    chk("init_busy_low", busy, 0);

    // ---- table-driven RX frames ----
    for (int i = 0; i < 7; i++) begin
      logic [7:0] f;
      f = rx_tab[i].flag;
      rdy_mode = rx_tab[i].mode;
      build_page(rx_tab[i].plen, rx_tab[i].fixed);
      push_acc(0, A_INT_FLAG, 8'h00);
      if ((f & 8'h0C) != 0) push_acc(1, A_RX_CTRL, 8'h0C);
      if (f[6]) push_acc(1, A_TX_CTRL, 8'h08);
      if ((f & 8'h4C) != 0) push_acc(0, A_INT_FLAG, 8'h00);
      if (f[1]) expect_rx(rx_tab[i].plen);
      err_seen = 0;
      load_flag(f);
      wait_done(3000);
      chk("rx_err_pulses", err_seen, rx_tab[i].exp_err);
    end
    rdy_mode = 0;

    // ---- table-driven TX frames ----
    load_flag(8'h10);
    for (int i = 0; i < 5; i++) begin
      int  n;
      int  nw;
      logic acc;
      n  = tx_tab[i].n;
      nw = (n > MAXF) ? MAXF : n;
      for (int k = 0; k < n; k++) tx_buf[k] = tx_tab[i].fixed ? tx_fix[k] : 8'($urandom_range(0, 255));
      push_acc(0, A_INT_FLAG, 8'h00);
      for (int k = 0; k < nw; k++) push_acc(1, A_TX, tx_buf[k]);
      push_acc(1, A_TX_CTRL, (n > MAXF) ? 8'h01 : 8'h02);
      err_seen = 0;
      for (int k = 0; k < n; k++) begin
        if (tx_tab[i].gaps && $urandom_range(0, 2) == 0) begin
          tx_valid = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
        end
        tx_valid = 1'b1;
        tx_data  = tx_buf[k];
        tx_last  = (k == n - 1);
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
          tick();
          acc = tx_acc_seen;
        end
        if (!acc) begin
          chk("tx_accept_in_budget", acc, 1);
          break;
        end
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      wait_done(3000);
      chk("tx_err_pulses", err_seen, tx_tab[i].exp_err);
    end

    // ---- reset in the middle of an RX frame ----
    build_page(20, 1'b0);
    push_acc(0, A_INT_FLAG, 8'h00);
    expect_rx(20);
    load_flag(8'h12);
    repeat (14) tick();
    chk("midframe_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midreset_strobes", {csr_read, csr_write, tx_ready, rx_valid, rx_last, err, busy}, 0);
    chk("midreset_address", {csr_address, csr_writedata, rx_data}, 0);
    exp_q.delete();
    rx_exp_q.delete();
    hold_q = 1'b0;
    repeat (3) tick();
    push_acc(1, A_INT_MASK, 8'h4E);
    push_acc(0, A_INT_FLAG, 8'h00);
    expect_rx(20);
    reset = 1'b0;
    wait_done(3000);
    chk("after_restart_flag", flag, 8'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
